// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared encodings for the radix-4 Booth multiplier family
package booth_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } state_t;

    typedef enum logic [2:0] {
        SEL_ZERO,
        SEL_PM1,
        SEL_MM1,
        SEL_PM2,
        SEL_MM2
    } sel_t;

endpackage

// File: rtl/booth_r4_recoder.sv
// rtl/booth_r4_recoder.sv - radix-4 Booth window {b1,b0,prev} to partial-product select
module booth_r4_recoder
    import booth_pkg::*;
(
    input  logic [2:0] window,
    output logic [2:0] sel
);

    always_comb begin
        sel = SEL_ZERO;
        case (window)
            3'b001, 3'b010: sel = SEL_PM1;
            3'b011:         sel = SEL_PM2;
            3'b100:         sel = SEL_MM2;
            3'b101, 3'b110: sel = SEL_MM1;
            default:        sel = SEL_ZERO;
        endcase
    end

endmodule

// File: rtl/booth_radix4_mult.sv
// rtl/booth_radix4_mult.sv - sequential radix-4 Booth multiplier, signed/unsigned, start/busy/done
module booth_radix4_mult
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int N_ITER = (WIDTH / 2) + 1;
    localparam int XW     = WIDTH + 2;
    localparam int HW     = WIDTH + 3;
    localparam int CW     = $clog2(N_ITER + 1);

    generate
        if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
            $error("booth_radix4_mult: WIDTH must be even and >= 4");
        end
    endgenerate

    state_t             state, state_nx;
    logic [XW-1:0]      m_q, lo_q;
    logic [HW-1:0]      hi_q;
    logic               prev_q;
    logic [CW-1:0]      cnt_q;
    logic               done_q;
    logic [2*WIDTH-1:0] product_q;

    logic [2:0]         sel;
    logic [HW-1:0]      m_sx, addend, hi_sum;

    function automatic logic [XW-1:0] ext(input logic [WIDTH-1:0] v, input logic sm);
        logic s;
        s = sm & v[WIDTH-1];
        return {{2{s}}, v};
    endfunction

    booth_r4_recoder u_recoder (
        .window ({lo_q[1:0], prev_q}),
        .sel    (sel)
    );

    always_comb begin
        m_sx   = {m_q[XW-1], m_q};
        addend = '0;
        case (sel)
            SEL_PM1: addend = m_sx;
            SEL_MM1: addend = -m_sx;
            SEL_PM2: addend = m_sx << 1;
            SEL_MM2: addend = -(m_sx << 1);
            default: addend = '0;
        endcase
        hi_sum = hi_q + addend;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (start) state_nx = ST_CALC;
            ST_CALC: if (cnt_q == CW'(1)) state_nx = ST_DONE;
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            m_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            prev_q    <= 1'b0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            state  <= state_nx;
            // done is registered so it rises together with the new product
            done_q <= (state == ST_DONE);
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        m_q    <= ext(multiplicand, signed_mode);
                        lo_q   <= ext(multiplier, signed_mode);
                        hi_q   <= '0;
                        prev_q <= 1'b0;
                        cnt_q  <= CW'(N_ITER);
                    end
                end
                ST_CALC: begin
                    hi_q   <= {{2{hi_sum[HW-1]}}, hi_sum[HW-1:2]};
                    lo_q   <= {hi_sum[1:0], lo_q[XW-1:2]};
                    prev_q <= lo_q[1];
                    cnt_q  <= cnt_q - CW'(1);
                end
                ST_DONE: begin
                    // all WIDTH+2 multiplier bits have been shifted out, so LO holds the low product bits
                    product_q <= {hi_q[WIDTH-3:0], lo_q};
                end
                default: ;
            endcase
        end
    end

    assign busy    = (state != ST_IDLE);
    assign done    = done_q;
    assign product = product_q;

endmodule
